// File: rtl/morse_scheduler_if.sv
// morse_scheduler_if: UART-side and generator-side signals of the
// character scheduler; slave = scheduler, master = surrounding logic.
interface morse_scheduler_if #(
  parameter int WORD_BITS = 8
);
  logic [WORD_BITS-1:0] rx_data_i;
  logic                 rx_done_i;
  logic                 flush_i;
  logic [WORD_BITS-1:0] gen_ascii_o;
  logic                 gen_en_o;
  logic                 gen_done_i;
  logic [WORD_BITS-1:0] cur_char_o;
  logic                 busy_o;
  logic                 fifo_empty_o;
  logic                 fifo_full_o;
  logic                 drop_o;

  modport slave (
    input  rx_data_i, rx_done_i, flush_i, gen_done_i,
    output gen_ascii_o, gen_en_o, cur_char_o, busy_o,
    output fifo_empty_o, fifo_full_o, drop_o
  );

  modport master (
    output rx_data_i, rx_done_i, flush_i, gen_done_i,
    input  gen_ascii_o, gen_en_o, cur_char_o, busy_o,
    input  fifo_empty_o, fifo_full_o, drop_o
  );
endinterface

// File: rtl/morse_scheduler.sv
// morse_scheduler: byte FIFO + issue/gap FSM feeding the morse generator.
// Optional MORSE_SCHED_UPCASE_EN folds lowercase letters to uppercase.
module morse_scheduler #(
  parameter int WORD_BITS      = 8,
  parameter int FIFO_ADDR_BITS = 3,
  parameter int UNIT_CYCLES    = 20_000_000,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7
) (
  input  logic clk_i,
  input  logic reset_ni,
  morse_scheduler_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int AW = FIFO_ADDR_BITS;
  localparam int CW =
    (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int UW = $clog2(WORD_GAP_UNITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t               state;
  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [AW:0]          count_nx;
  logic [CW-1:0]        cyc;
  logic [UW-1:0]        units;
  logic [UW-1:0]        gap;
  logic                 flush_pend;
  logic                 pop;
  logic                 push;
  logic [WORD_BITS-1:0] head;
  logic [WORD_BITS-1:0] conv;
  logic                 is_space;
  logic                 printable;

  assign head = mem[rd_ptr];
  assign pop  = (state == S_IDLE) && !bus.fifo_empty_o
             && !bus.flush_i;
  assign push = bus.rx_done_i && !bus.flush_i
             && (!bus.fifo_full_o || pop);

`ifdef MORSE_SCHED_UPCASE_EN
  assign conv =
    (head >= WORD_BITS'(8'h61) && head <= WORD_BITS'(8'h7A))
    ? head - WORD_BITS'(8'h20) : head;
`else
  assign conv = head;
`endif

  assign is_space  = conv == WORD_BITS'(8'h20);
  assign printable = conv >= WORD_BITS'(8'h21)
                  && conv <= WORD_BITS'(8'h7E);

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  // Queue storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= bus.rx_data_i;
  end

  // Pointers, occupancy, registered flags and overflow pulse.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      bus.fifo_empty_o <= 1'b1;
      bus.fifo_full_o  <= 1'b0;
      bus.drop_o       <= 1'b0;
    end else begin
      bus.drop_o <= bus.rx_done_i && !bus.flush_i
                 && bus.fifo_full_o && !pop;
      if (bus.flush_i) begin
        wr_ptr           <= '0;
        rd_ptr           <= '0;
        count            <= '0;
        bus.fifo_empty_o <= 1'b1;
        bus.fifo_full_o  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count            <= count_nx;
        bus.fifo_empty_o <= count_nx == '0;
        bus.fifo_full_o  <= count_nx == (AW+1)'(DEPTH);
      end
    end
  end

  // Issue / handshake / gap sequencer with registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state           <= S_IDLE;
      cyc             <= '0;
      units           <= '0;
      gap             <= '0;
      flush_pend      <= 1'b0;
      bus.gen_ascii_o <= '0;
      bus.gen_en_o    <= 1'b0;
      bus.cur_char_o  <= '0;
      bus.busy_o      <= 1'b0;
    end else begin
      bus.gen_en_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            unique case (1'b1)
              is_space: begin
                bus.cur_char_o <= conv;
                gap            <= UW'(WORD_GAP_UNITS);
                cyc            <= '0;
                units          <= '0;
                state          <= S_GAP;
                bus.busy_o     <= 1'b1;
              end
              printable: begin
                bus.gen_ascii_o <= conv;
                bus.cur_char_o  <= conv;
                bus.gen_en_o    <= 1'b1;
                state           <= S_ISSUE;
                bus.busy_o      <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_ISSUE: begin
          if (bus.flush_i) begin
            state      <= S_IDLE;
            bus.busy_o <= 1'b0;
            cyc        <= '0;
            units      <= '0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.flush_i) flush_pend <= 1'b1;
          if (bus.gen_done_i) begin
            flush_pend <= 1'b0;
            if (flush_pend || bus.flush_i) begin
              state      <= S_IDLE;
              bus.busy_o <= 1'b0;
            end else begin
              gap   <= UW'(CHAR_GAP_UNITS);
              cyc   <= '0;
              units <= '0;
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (bus.flush_i) begin
            state      <= S_IDLE;
            bus.busy_o <= 1'b0;
            cyc        <= '0;
            units      <= '0;
          end else if (cyc == CW'(UNIT_CYCLES - 1)) begin
            cyc <= '0;
            if (units + UW'(1) == gap) begin
              units      <= '0;
              state      <= S_IDLE;
              bus.busy_o <= 1'b0;
            end else begin
              units <= units + UW'(1);
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: begin
          state      <= S_IDLE;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_morse_scheduler.sv
// tb_morse_scheduler: directed stimulus, queued expected issues,
// negedge monitor compares every generator start strobe.
module tb_morse_scheduler;
  localparam int WB = 8;
  localparam int UC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  morse_scheduler_if #(.WORD_BITS(WB)) bus();

  morse_scheduler #(
    .WORD_BITS(WB),
    .FIFO_ADDR_BITS(3),
    .UNIT_CYCLES(UC),
    .CHAR_GAP_UNITS(3),
    .WORD_GAP_UNITS(7)
  ) dut (
    .clk_i(clk),
    .reset_ni(rst_n),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;
  logic [15:0] expq[$];
  logic [15:0] e;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every start strobe must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.gen_en_o === 1'b1) begin
      if (expq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_gen_en: got ascii %0h want none",
                 bus.gen_ascii_o);
      end else begin
        e = expq.pop_front();
        chk("gen_ascii", 32'(bus.gen_ascii_o), 32'(e[15:8]));
        chk("cur_char", 32'(bus.cur_char_o), 32'(e[7:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(logic [7:0] b);
    bus.rx_data_i = b;
    bus.rx_done_i = 1'b1;
    tick();
    bus.rx_done_i = 1'b0;
  endtask

  task automatic pulse_done();
    bus.gen_done_i = 1'b1;
    tick();
    bus.gen_done_i = 1'b0;
  endtask

  task automatic wait_en(int bound);
    int n = 0;
    while (bus.gen_en_o !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    if (bus.gen_en_o !== 1'b1) begin
      vecs++;
      errs++;
      $display("FAIL wait_en_timeout: got 0 want 1");
    end
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while (bus.busy_o !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    if (bus.busy_o !== 1'b0) begin
      vecs++;
      errs++;
      $display("FAIL wait_idle_timeout: got 1 want 0");
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ascii"}, 32'(bus.gen_ascii_o), 0);
    chk({tag, "_en"}, 32'(bus.gen_en_o), 0);
    chk({tag, "_cur"}, 32'(bus.cur_char_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    chk({tag, "_empty"}, 32'(bus.fifo_empty_o), 1);
    chk({tag, "_full"}, 32'(bus.fifo_full_o), 0);
    chk({tag, "_drop"}, 32'(bus.drop_o), 0);
  endtask

  initial begin
    int n;
    int ndrop;
    logic seen;
    logic [7:0] up;

    bus.rx_data_i  = '0;
    bus.rx_done_i  = 1'b0;
    bus.flush_i    = 1'b0;
    bus.gen_done_i = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk_reset_vals("rst");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single character and char-gap length.
    expq.push_back({8'h45, 8'h45});
    rx(8'h45);
    chk("single_empty", 32'(bus.fifo_empty_o), 0);
    chk("single_en_early", 32'(bus.gen_en_o), 0);
    tick();
    chk("single_en", 32'(bus.gen_en_o), 1);
    tick();
    pulse_done();
    n = 0;
    while (bus.busy_o === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("char_gap_cycles", n, 12);

    // Word gap between two characters.
    expq.push_back({8'h41, 8'h41});
    expq.push_back({8'h42, 8'h42});
    rx(8'h41);
    rx(8'h20);
    rx(8'h42);
    pulse_done();
    n = 0;
    seen = 1'b0;
    while (bus.gen_en_o !== 1'b1 && n < 200) begin
      if (bus.cur_char_o === 8'h20) seen = 1'b1;
      tick();
      n++;
    end
    chk("word_gap_edges", n, 42);
    chk("cur_char_space", 32'(seen), 1);
    tick();
    pulse_done();
    wait_idle(100);

    // Control byte is filtered with no gap.
    expq.push_back({8'h53, 8'h53});
    rx(8'h0A);
    rx(8'h53);
    chk("filter_busy", 32'(bus.busy_o), 0);
    chk("filter_en_early", 32'(bus.gen_en_o), 0);
    tick();
    chk("filter_en", 32'(bus.gen_en_o), 1);
    tick();
    pulse_done();
    wait_idle(100);

    // Overflow: one issued, eight queued, one dropped.
    for (int k = 0; k < 9; k++)
      expq.push_back({8'(8'h30 + k), 8'(8'h30 + k)});
    ndrop = 0;
    for (int k = 0; k < 10; k++) begin
      rx(8'(8'h30 + k));
      if (bus.drop_o === 1'b1) ndrop++;
    end
    chk("ovf_full", 32'(bus.fifo_full_o), 1);
    chk("ovf_empty", 32'(bus.fifo_empty_o), 0);
    repeat (2) begin
      tick();
      if (bus.drop_o === 1'b1) ndrop++;
    end
    chk("ovf_drop_count", ndrop, 1);
    pulse_done();
    wait_idle(100);
    chk("full_before_pp", 32'(bus.fifo_full_o), 1);
    expq.push_back({8'h5A, 8'h5A});
    rx(8'h5A);
    chk("pp_full", 32'(bus.fifo_full_o), 1);
    chk("pp_drop", 32'(bus.drop_o), 0);
    repeat (9) begin
      wait_en(100);
      tick();
      pulse_done();
    end
    wait_idle(100);
    chk("drain_empty", 32'(bus.fifo_empty_o), 1);

    // Flush during a gap.
    expq.push_back({8'h46, 8'h46});
    rx(8'h46);
    rx(8'h47);
    rx(8'h48);
    rx(8'h49);
    pulse_done();
    repeat (2) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("fgap_empty", 32'(bus.fifo_empty_o), 1);
    chk("fgap_busy", 32'(bus.busy_o), 0);
    repeat (40) tick();
    chk("fgap_still_empty", 32'(bus.fifo_empty_o), 1);

    // Flush while waiting for the generator.
    expq.push_back({8'h4B, 8'h4B});
    rx(8'h4B);
    rx(8'h4C);
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("fwait_empty", 32'(bus.fifo_empty_o), 1);
    chk("fwait_busy", 32'(bus.busy_o), 1);
    repeat (3) tick();
    pulse_done();
    chk("fwait_idle", 32'(bus.busy_o), 0);
    repeat (20) tick();

    // Lowercase handling.
`ifdef MORSE_SCHED_UPCASE_EN
    up = 8'h45;
`else
    up = 8'h65;
`endif
    expq.push_back({up, up});
    rx(8'h65);
    wait_en(10);
    tick();
    pulse_done();
    wait_idle(100);

    // Asynchronous reset in WAIT_DONE.
    expq.push_back({8'h52, 8'h52});
    rx(8'h52);
    rx(8'h53);
    tick();
    chk("pre_rst_busy", 32'(bus.busy_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 32'(bus.busy_o), 0);

    chk("scoreboard_left", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
